maze_solver_ctrl: RTL and testbench

//  Depth-first-search controller that sequences the 16x16 single-bit maze memory.

---
 rtl/maze_solver_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_maze_solver_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_solver_ctrl.sv
// Depth-first-search maze solver controller.
// Drives a 16x16 single-bit maze memory: marks visited cells, probes neighbours,
// and backtracks through a 2-bit direction stack until the goal cell is reached
// or every reachable cell has been exhausted.
module maze_solver_ctrl #(
  parameter int GOAL_X      = 15,
  parameter int GOAL_Y      = 15,
  parameter int STACK_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       mem_din,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_dout,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [8:0] path_len,
  input  logic [7:0] path_idx,
  output logic [1:0] path_dir
);

  localparam logic [3:0] GX = 4'(GOAL_X);
  localparam logic [3:0] GY = 4'(GOAL_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_PROBE,
    S_CHECK,
    S_BACK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cur_x, cur_y, cur_x_nx, cur_y_nx;
  logic [8:0] sp, sp_nx, sp_dec;
  logic [2:0] dir, dir_nx;
  logic [3:0] last_x, last_y;
  logic       push;
  logic [1:0] stack [STACK_DEPTH];
  logic [1:0] top_dir;
  logic [3:0] nb_x, nb_y;
  logic       nb_ok;
  logic [3:0] back_x, back_y;

  assign sp_dec   = sp - 9'd1;
  assign top_dir  = stack[sp_dec[7:0]];
  assign path_dir = stack[path_idx];

  assign busy     = (state == S_MARK) || (state == S_PROBE) ||
                    (state == S_CHECK) || (state == S_BACK);
  assign done     = (state == S_DONE);
  assign fail     = (state == S_FAIL);
  assign path_len = (state == S_DONE) ? sp : 9'd0;

  // Neighbour of the current cell in the probe direction, plus whether it lies inside the grid
  always_comb begin
    nb_x  = cur_x;
    nb_y  = cur_y;
    nb_ok = 1'b0;
    case (dir)
      3'd0: begin nb_x = cur_x + 4'd1; nb_ok = (cur_x != 4'd15); end
      3'd1: begin nb_y = cur_y + 4'd1; nb_ok = (cur_y != 4'd15); end
      3'd2: begin nb_x = cur_x - 4'd1; nb_ok = (cur_x != 4'd0);  end
      3'd3: begin nb_y = cur_y - 4'd1; nb_ok = (cur_y != 4'd0);  end
      default: ;
    endcase
  end

  // Cell we return to when undoing the move on top of the stack
  always_comb begin
    back_x = cur_x;
    back_y = cur_y;
    case (top_dir)
      2'd0:    back_x = cur_x - 4'd1;
      2'd1:    back_y = cur_y - 4'd1;
      2'd2:    back_x = cur_x + 4'd1;
      default: back_y = cur_y + 4'd1;
    endcase
  end

  // Next-state logic, datapath updates and memory strobes
  always_comb begin
    state_nx = state;
    cur_x_nx = cur_x;
    cur_y_nx = cur_y;
    sp_nx    = sp;
    dir_nx   = dir;
    push     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_din  = 1'b0;
    mem_x    = last_x;
    mem_y    = last_y;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cur_x_nx = 4'd0;
          cur_y_nx = 4'd0;
          sp_nx    = 9'd0;
          dir_nx   = 3'd0;
          state_nx = S_MARK;
        end
      end
      S_MARK: begin
        mem_wr  = 1'b1;
        mem_din = 1'b1;
        mem_x   = cur_x;
        mem_y   = cur_y;
        if ((cur_x == GX) && (cur_y == GY)) begin
          state_nx = S_DONE;
        end else begin
          dir_nx   = 3'd0;
          state_nx = S_PROBE;
        end
      end
      S_PROBE: begin
        if (dir[2]) begin
          state_nx = S_BACK;
        end else if (!nb_ok) begin
          dir_nx = dir + 3'd1;
        end else begin
          mem_rd   = 1'b1;
          mem_x    = nb_x;
          mem_y    = nb_y;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!mem_dout) begin
          push     = 1'b1;
          sp_nx    = sp + 9'd1;
          cur_x_nx = nb_x;
          cur_y_nx = nb_y;
          state_nx = S_MARK;
        end else begin
          dir_nx   = dir + 3'd1;
          state_nx = S_PROBE;
        end
      end
      S_BACK: begin
        if (sp == 9'd0) begin
          state_nx = S_FAIL;
        end else begin
          sp_nx    = sp_dec;
          cur_x_nx = back_x;
          cur_y_nx = back_y;
          dir_nx   = {1'b0, top_dir} + 3'd1;
          state_nx = S_PROBE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and datapath registers; the last issued address is held between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cur_x  <= 4'd0;
      cur_y  <= 4'd0;
      sp     <= 9'd0;
      dir    <= 3'd0;
      last_x <= 4'd0;
      last_y <= 4'd0;
    end else begin
      state  <= state_nx;
      cur_x  <= cur_x_nx;
      cur_y  <= cur_y_nx;
      sp     <= sp_nx;
      dir    <= dir_nx;
      last_x <= mem_x;
      last_y <= mem_y;
    end
  end

  // Direction stack; contents are irrelevant after reset so it carries none
  always_ff @(posedge clk) begin
    if (push) begin
      stack[sp[7:0]] <= dir[1:0];
    end
  end

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Self-checking bench for maze_solver_ctrl.
// A transaction-level DFS model predicts every memory strobe, the outcome and the path;
// a negedge compare process checks each strobe, and directed tests pin known answers.
module tb_maze_solver_ctrl;

  localparam int GOAL_X = 15;
  localparam int GOAL_Y = 15;
  localparam int MAXT   = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_x, mem_y;
  logic       mem_din, mem_rd, mem_wr;
  logic       mem_dout = 1'b0;
  logic       busy, done, fail;
  logic [8:0] path_len;
  logic [7:0] path_idx = 8'd0;
  logic [1:0] path_dir;

  logic maze      [256];
  logic maze_init [256];
  logic reload = 1'b0;

  int  check_count = 0;
  int  fail_count  = 0;

  bit  exp_wr [MAXT];
  int  exp_x  [MAXT];
  int  exp_y  [MAXT];
  int  exp_total = 0;
  bit  exp_ok = 1'b0;
  int  exp_len = 0;
  int  path_model [256];
  int  test_id = 0;

  int  seen_id = 0;
  int  exp_ptr = 0;
  int  wr_count = 0;
  int  last_x = 0;
  int  last_y = 0;

  maze_solver_ctrl #(
    .GOAL_X(GOAL_X),
    .GOAL_Y(GOAL_Y),
    .STACK_DEPTH(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_x(mem_x),
    .mem_y(mem_y),
    .mem_din(mem_din),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_dout(mem_dout),
    .busy(busy),
    .done(done),
    .fail(fail),
    .path_len(path_len),
    .path_idx(path_idx),
    .path_dir(path_dir)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Maze memory with registered read data; reload copies the prepared maze in
  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 256; i++) maze[i] <= maze_init[i];
    end else begin
      if (mem_wr) maze[{mem_y, mem_x}] <= mem_din;
      if (mem_rd) mem_dout <= maze[{mem_y, mem_x}];
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare every strobe against the predicted transaction list; address must hold otherwise
  always @(negedge clk) begin
    if (test_id != seen_id) begin
      seen_id  = test_id;
      exp_ptr  = 0;
      wr_count = 0;
    end
    if (rst) begin
      last_x = 0;
      last_y = 0;
    end else if (mem_rd || mem_wr) begin
      checkOutput("rd_wr_exclusive", int'(mem_rd & mem_wr), 0);
      if (mem_wr) wr_count++;
      if (exp_ptr >= exp_total) begin
        checkOutput("extra_strobe", exp_ptr + 1, exp_total);
      end else begin
        checkOutput("strobe_is_write", int'(mem_wr), int'(exp_wr[exp_ptr]));
        checkOutput("strobe_x", int'(mem_x), exp_x[exp_ptr]);
        checkOutput("strobe_y", int'(mem_y), exp_y[exp_ptr]);
        if (mem_wr) checkOutput("write_data", int'(mem_din), 1);
        exp_ptr++;
      end
      last_x = int'(mem_x);
      last_y = int'(mem_y);
    end else begin
      checkOutput("hold_x", int'(mem_x), last_x);
      checkOutput("hold_y", int'(mem_y), last_y);
    end
  end

  task automatic set_maze(input int pat);
    for (int i = 0; i < 256; i++) maze_init[i] = 1'b0;
    case (pat)
      1: for (int y = 0; y < 15; y++) maze_init[y * 16 + 1] = 1'b1;
      2: begin maze_init[0 * 16 + 1] = 1'b1; maze_init[1 * 16 + 0] = 1'b1; end
      3: begin maze_init[0 * 16 + 2] = 1'b1; maze_init[1 * 16 + 1] = 1'b1; end
      default: ;
    endcase
  endtask

  // Recursive DFS expressed with an explicit frame stack: each frame owns a cell and the next direction to try
  task automatic build_model();
    logic m  [256];
    int   fx [256];
    int   fy [256];
    int   fd [256];
    int   depth, n, nx, ny;
    bit   fin;
    for (int i = 0; i < 256; i++) m[i] = maze_init[i];
    depth = 0;
    fx[0] = 0; fy[0] = 0; fd[0] = 0;
    exp_wr[0] = 1'b1; exp_x[0] = 0; exp_y[0] = 0;
    n = 1;
    m[0] = 1'b1;
    exp_ok = (GOAL_X == 0) && (GOAL_Y == 0);
    fin = exp_ok;
    while (!fin) begin
      if (fd[depth] == 4) begin
        if (depth == 0) fin = 1'b1;
        else begin
          depth--;
          fd[depth]++;
        end
      end else begin
        nx = fx[depth] + ((fd[depth] == 0) ? 1 : (fd[depth] == 2) ? -1 : 0);
        ny = fy[depth] + ((fd[depth] == 1) ? 1 : (fd[depth] == 3) ? -1 : 0);
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
          fd[depth]++;
        end else begin
          exp_wr[n] = 1'b0; exp_x[n] = nx; exp_y[n] = ny; n++;
          if (m[ny * 16 + nx] == 1'b0) begin
            path_model[depth] = fd[depth];
            depth++;
            fx[depth] = nx; fy[depth] = ny; fd[depth] = 0;
            exp_wr[n] = 1'b1; exp_x[n] = nx; exp_y[n] = ny; n++;
            m[ny * 16 + nx] = 1'b1;
            if (nx == GOAL_X && ny == GOAL_Y) begin
              exp_ok = 1'b1;
              fin = 1'b1;
            end
          end else begin
            fd[depth]++;
          end
        end
      end
    end
    exp_total = n;
    exp_len   = exp_ok ? depth : 0;
  endtask

  task automatic checkDir(input int idx, input int want, input string name);
    path_idx = 8'(idx);
    #1;
    checkOutput(name, int'(path_dir), want);
  endtask

  task automatic prepare(input int pat);
    set_maze(pat);
    build_model();
    test_id++;
    @(negedge clk) reload = 1'b1;
    @(negedge clk) reload = 1'b0;
  endtask

  // Run one solve on a maze pattern, optionally poking start while busy, and check the outcome
  task automatic applyStimulus(input int pat, input bit poke, output int cycles);
    int cyc;
    prepare(pat);
    start = 1'b1;
    cyc = 0;
    while (cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 10) ? 1'b1 : 1'b0;
      if (done || fail) break;
    end
    cycles = cyc;
    if (!(done || fail)) checkOutput("solve_timeout", cyc, -1);
    checkOutput("done", int'(done), int'(exp_ok));
    checkOutput("fail", int'(fail), int'(!exp_ok));
    checkOutput("busy_after", int'(busy), 0);
    checkOutput("path_len", int'(path_len), exp_len);
    for (int i = 0; i < exp_len; i++) checkDir(i, path_model[i], "path_dir_model");
    checkOutput("all_strobes_seen", exp_ptr, exp_total);
  endtask

  initial begin
    int cycles;
    $display("[TB] maze_solver_ctrl bench starting");
    for (int i = 0; i < 256; i++) maze_init[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_fail", int'(fail), 0);
    checkOutput("reset_rd", int'(mem_rd), 0);
    checkOutput("reset_wr", int'(mem_wr), 0);
    checkOutput("reset_din", int'(mem_din), 0);
    checkOutput("reset_path_len", int'(path_len), 0);
    checkOutput("reset_addr", int'({mem_y, mem_x}), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: open maze");
    applyStimulus(0, 1'b0, cycles);
    checkOutput("t1_model_len", exp_len, 30);
    checkOutput("t1_len", int'(path_len), 30);
    checkDir(0, 0, "t1_dir0");
    checkDir(14, 0, "t1_dir14");
    checkDir(15, 1, "t1_dir15");
    checkDir(29, 1, "t1_dir29");

    $display("[TB] test 2: wall column at x=1, start pulsed while busy");
    applyStimulus(1, 1'b1, cycles);
    checkOutput("t2_len", int'(path_len), 30);
    checkDir(0, 1, "t2_dir0");
    checkDir(14, 1, "t2_dir14");
    checkDir(15, 0, "t2_dir15");
    checkDir(29, 0, "t2_dir29");

    $display("[TB] test 3: start cell boxed in");
    applyStimulus(2, 1'b0, cycles);
    checkOutput("t3_fail", int'(fail), 1);
    checkOutput("t3_done", int'(done), 0);
    checkOutput("t3_len", int'(path_len), 0);
    checkOutput("t3_fast", int'(cycles <= 12), 1);
    checkOutput("t3_writes", wr_count, 1);

    $display("[TB] test 4: dead-end corridor");
    applyStimulus(3, 1'b0, cycles);
    checkOutput("t4_done", int'(done), 1);
    checkOutput("t4_len", int'(path_len), 30);
    checkDir(0, 1, "t4_dir0");
    checkDir(1, 1, "t4_dir1");
    checkDir(2, 0, "t4_dir2");

    $display("[TB] test 5: reset mid-solve then re-solve");
    prepare(0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t5_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_done", int'(done), 0);
    checkOutput("t5_fail", int'(fail), 0);
    checkOutput("t5_rd", int'(mem_rd), 0);
    checkOutput("t5_wr", int'(mem_wr), 0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 1'b0, cycles);
    checkOutput("t5_len", int'(path_len), 30);
    checkDir(15, 1, "t5_dir15");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
